// File: rtl/vga_descrambler_if.sv
// rtl/vga_descrambler_if.sv - RGB444 pixel stream bundle (valid plus colour nibbles)
interface vga_descrambler_if;
    logic       valid;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;

    modport master (output valid, output red, output green, output blue);
    modport slave  (input  valid, input  red, input  green, input  blue);
endinterface

// File: rtl/vga_descrambler.sv
// rtl/vga_descrambler.sv - receive-side VGA pixel descrambler with frame lock and pixel-count check
module vga_descrambler #(
    parameter logic [11:0] KEY_SEED     = 12'hACE,
    parameter int          FRAME_PIXELS = 307200,
    parameter int          CNT_W        = 19
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    seed_req_i,
    input  logic [11:0]             code_i,
    vga_descrambler_if.slave        pix_i,
    vga_descrambler_if.master       pix_o,
    output logic                    locked_o,
    output logic                    frame_err_o
);
    localparam logic [0:0] ST_UNLOCKED = 1'b0;
    localparam logic [0:0] ST_LOCKED   = 1'b1;
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_PIXELS);

    logic [0:0]       state_q, state_d;
    logic             seed_q;
    logic [11:0]      key_q, key_d;
    logic [11:0]      code_q, code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [11:0]      rgb_q, rgb_d;
    logic             frame_err_q, frame_err_d;
    logic             reseed;
    logic [11:0]      rgb_in;

    function automatic logic [11:0] key_step(input logic [11:0] k);
        return {k[11] ^ k[10] ^ k[9] ^ k[3], k[11:1]};
    endfunction

    function automatic logic [11:0] code_step(input logic [11:0] c);
        return {c[11] ^ c[5] ^ c[3] ^ c[0], c[11:1]};
    endfunction

    assign reseed = seed_req_i & ~seed_q;
    assign rgb_in = {pix_i.red, pix_i.green, pix_i.blue};

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        code_d      = code_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        rgb_d       = rgb_q;
        frame_err_d = 1'b0;
        case (state_q)
            ST_UNLOCKED: begin
                if (reseed) begin
                    key_d   = KEY_SEED;
                    code_d  = code_i;
                    cnt_d   = '0;
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                // A reseed edge closes the frame; any pixel in the same cycle is dropped.
                if (reseed) begin
                    key_d       = KEY_SEED;
                    code_d      = code_i;
                    cnt_d       = '0;
                    frame_err_d = (cnt_q != FRAME_CNT);
                end else if (pix_i.valid) begin
                    if (cnt_q < FRAME_CNT) begin
                        rgb_d       = rgb_in ^ key_q ^ code_q;
                        out_valid_d = 1'b1;
                        key_d       = key_step(key_q);
                        code_d      = code_step(code_q);
                        cnt_d       = cnt_q + CNT_W'(1);
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_UNLOCKED;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_UNLOCKED;
            seed_q      <= 1'b0;
            key_q       <= KEY_SEED;
            code_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            rgb_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_req_i;
            key_q       <= key_d;
            code_q      <= code_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            rgb_q       <= rgb_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign pix_o.valid = out_valid_q;
    assign pix_o.red   = rgb_q[11:8];
    assign pix_o.green = rgb_q[7:4];
    assign pix_o.blue  = rgb_q[3:0];
    assign locked_o    = (state_q == ST_LOCKED);
    assign frame_err_o = frame_err_q;
endmodule

// File: tb/tb_vga_descrambler.sv
// tb/tb_vga_descrambler.sv - scoreboard bench: sender-side scrambler model feeding the descrambler
module tb_vga_descrambler;
    localparam int FP = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        seed_req = 1'b0;
    logic [11:0] code = '0;
    logic        locked;
    logic        frame_err;

    vga_descrambler_if pin ();
    vga_descrambler_if pout ();

    vga_descrambler #(
        .KEY_SEED    (12'hACE),
        .FRAME_PIXELS(FP),
        .CNT_W       (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .seed_req_i (seed_req),
        .code_i     (code),
        .pix_i      (pin.slave),
        .pix_o      (pout.master),
        .locked_o   (locked),
        .frame_err_o(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [11:0] data;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;
    int   err_seen = 0;
    int   err_exp = 0;

    logic [11:0] m_key = 12'hACE;
    logic [11:0] m_code = '0;
    int          m_cnt = 0;
    bit          m_lock = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (frame_err === 1'b1) err_seen++;
        if (pout.valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("latency", cyc, e.cyc);
                chk("pixel", {pout.red, pout.green, pout.blue}, e.data);
            end
        end
    end

    function automatic logic [11:0] key_step(input logic [11:0] k);
        return {k[11] ^ k[10] ^ k[9] ^ k[3], k[11:1]};
    endfunction

    function automatic logic [11:0] code_step(input logic [11:0] c);
        return {c[11] ^ c[5] ^ c[3] ^ c[0], c[11:1]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic model_load(input logic [11:0] c);
        if (m_lock && m_cnt != FP) err_exp++;
        m_key  = 12'hACE;
        m_code = c;
        m_cnt  = 0;
        m_lock = 1'b1;
    endtask

    // Drive one scrambled word; if the model accepts it, expect exp_plain one cycle later.
    task automatic drive(input logic [11:0] raw, input logic [11:0] exp_plain);
        pin.valid = 1'b1;
        {pin.red, pin.green, pin.blue} = raw;
        if (m_lock) begin
            if (m_cnt < FP) begin
                sb.push_back('{cyc + 1, exp_plain});
                m_key  = key_step(m_key);
                m_code = code_step(m_code);
                m_cnt++;
            end else begin
                err_exp++;
                m_lock = 1'b0;
            end
        end
        tick();
        pin.valid = 1'b0;
    endtask

    task automatic send_pixel(input logic [11:0] plain);
        drive(plain ^ m_key ^ m_code, plain);
    endtask

    task automatic reseed(input logic [11:0] c, input bit with_px);
        seed_req = 1'b1;
        code = c;
        if (with_px) begin
            pin.valid = 1'b1;
            {pin.red, pin.green, pin.blue} = 12'($urandom);
        end
        model_load(c);
        tick();
        chk("locked_after_edge", locked, 1);
        seed_req = 1'b0;
        pin.valid = 1'b0;
        tick();
    endtask

    initial begin
        pin.valid = 1'b0;
        {pin.red, pin.green, pin.blue} = '0;
        idle(3);
        chk("rst_locked", locked, 0);
        chk("rst_valid", pout.valid, 0);
        chk("rst_rgb", {pout.red, pout.green, pout.blue}, 12'h000);
        chk("rst_ferr", frame_err, 0);
        reset = 1'b0;

        // Unlocked: pixel ignored
        drive(12'hFFF, 12'h000);
        idle(1);
        chk("unl_valid", pout.valid, 0);
        chk("unl_locked", locked, 0);
        chk("unl_rgb", {pout.red, pout.green, pout.blue}, 12'h000);

        // Directed descramble vectors
        reseed(12'h001, 1'b0);
        drive(12'hFFF, 12'h530);
        drive(12'h000, 12'h567);
        send_pixel(12'($urandom));
        send_pixel(12'($urandom));

        // Loopback, three full frames with random gaps
        for (int f = 0; f < 3; f++) begin
            reseed(12'($urandom), 1'b0);
            for (int p = 0; p < FP; p++) begin
                send_pixel(12'($urandom));
                idle($urandom_range(0, 2));
            end
        end
        reseed(12'($urandom), 1'b0);
        idle(2);
        chk("loop_ferr", err_seen, err_exp);

        // Short frame closed by an edge with a coincident pixel
        for (int p = 0; p < 3; p++) send_pixel(12'($urandom));
        reseed(12'($urandom), 1'b1);
        send_pixel(12'($urandom));
        idle(2);
        chk("short_ferr", err_seen, err_exp);

        // Overrun then relock
        for (int p = 0; p < 4; p++) send_pixel(12'($urandom));
        idle(2);
        chk("ovr_locked", locked, 0);
        chk("ovr_ferr", err_seen, err_exp);
        send_pixel(12'($urandom));
        reseed(12'($urandom), 1'b0);
        send_pixel(12'($urandom));
        idle(2);
        chk("relock_ferr", err_seen, err_exp);

        // Mid-frame reset, pixels without reseed
        send_pixel(12'($urandom));
        idle(2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_lock = 1'b0;
        m_cnt = 0;
        send_pixel(12'($urandom));
        send_pixel(12'($urandom));
        idle(1);
        chk("mrst_valid", pout.valid, 0);
        chk("mrst_rgb", {pout.red, pout.green, pout.blue}, 12'h000);
        chk("mrst_locked", locked, 0);

        // seed_req held high through reset gives an edge afterwards
        reset = 1'b1;
        seed_req = 1'b1;
        code = 12'($urandom);
        idle(2);
        reset = 1'b0;
        model_load(code);
        tick();
        chk("held_relock", locked, 1);
        seed_req = 1'b0;
        tick();
        for (int p = 0; p < FP; p++) send_pixel(12'($urandom));
        reseed(12'($urandom), 1'b0);
        idle(3);
        chk("final_ferr", err_seen, err_exp);
        chk("drain", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
